// File: rtl/gesture_pkg.sv
// Shared constants for the gesture-driven servo hand: pulse limits, pose table
// and the one-hot gesture decoder.
package gesture_pkg;

  typedef logic [15:0] us_t;

  localparam us_t NEUTRAL_US = 16'd1500;
  localparam us_t MIN_US     = 16'd1000;
  localparam us_t MAX_US     = 16'd2000;

  localparam int unsigned TBL_POSES = 8;
  localparam int unsigned TBL_CH    = 5;

  // Rows are poses, columns thumb..pinky; pose 7 holds out-of-range entries
  // that only become usable after clamping.
  localparam us_t POSE_TABLE [TBL_POSES][TBL_CH] = '{
    '{16'd1500, 16'd1500, 16'd1500, 16'd1500, 16'd1500},
    '{16'd1400, 16'd1400, 16'd1400, 16'd1400, 16'd1400},
    '{16'd1000, 16'd1800, 16'd1800, 16'd1800, 16'd1800},
    '{16'd1000, 16'd1000, 16'd1800, 16'd1800, 16'd1800},
    '{16'd1000, 16'd1000, 16'd1000, 16'd1800, 16'd1800},
    '{16'd1800, 16'd1800, 16'd1800, 16'd1800, 16'd1800},
    '{16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000},
    '{16'd2200, 16'd900,  16'd1700, 16'd1500, 16'd1300}
  };

  typedef struct packed {
    logic       valid;
    logic [2:0] idx;
  } pose_sel_t;

  function automatic pose_sel_t decode_gesture(input logic [7:0] g,
                                               input int unsigned num_poses);
    pose_sel_t s;
    s = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (g[3'(i)]) s.idx = 3'(i);
    end
    s.valid = ($countones(g) == 1) && ({29'b0, s.idx} < num_poses);
    return s;
  endfunction

  function automatic us_t pose_us(input pose_sel_t sel, input int unsigned ch);
    if (!sel.valid || ch >= TBL_CH) return NEUTRAL_US;
    return POSE_TABLE[sel.idx][3'(ch)];
  endfunction

endpackage

// File: rtl/servo_slew_channel.sv
// One servo channel: holds width/target, clamps the pose value and drives the
// PWM compare. GESTURE_POSE_SLEW_EN selects ramped rather than stepped widths.
module servo_slew_channel
  import gesture_pkg::*;
#(
  parameter int unsigned STEP_US = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_start,
  input  logic        i_load,
  input  logic [15:0] i_pose_us,
  input  logic [15:0] i_us_cnt,
  output logic        o_pwm,
  output logic [15:0] o_width,
  output logic        o_busy
);

`ifdef GESTURE_POSE_SLEW_EN
  localparam bit SLEW_EN = 1'b1;
`else
  localparam bit SLEW_EN = 1'b0;
`endif
  localparam us_t STEP = us_t'(STEP_US);

  us_t  r_width;
  us_t  r_target;
  logic r_pwm;
  us_t  w_clamped;
  us_t  w_width_nxt;
  us_t  w_step;

  always_comb begin
    w_clamped = i_pose_us;
    if (i_pose_us < MIN_US)      w_clamped = MIN_US;
    else if (i_pose_us > MAX_US) w_clamped = MAX_US;
  end

  always_comb begin
    w_width_nxt = r_target;
    w_step      = '0;
    if (SLEW_EN) begin
      if (r_target > r_width) begin
        w_step = r_target - r_width;
        if (w_step > STEP) w_step = STEP;
        w_width_nxt = r_width + w_step;
      end else begin
        w_step = r_width - r_target;
        if (w_step > STEP) w_step = STEP;
        w_width_nxt = r_width - w_step;
      end
    end
  end

  // Width moves only at frame start, using the target held before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_width  <= NEUTRAL_US;
      r_target <= NEUTRAL_US;
      r_pwm    <= 1'b0;
    end else begin
      r_pwm <= (i_us_cnt < r_width);
      if (i_frame_start) r_width  <= w_width_nxt;
      if (i_load)        r_target <= w_clamped;
    end
  end

  assign o_pwm   = r_pwm;
  assign o_width = r_width;
  assign o_busy  = (r_width != r_target);

endmodule

// File: rtl/gesture_pose_ctrl.sv
// Gesture-to-pose servo controller: frame timing, gesture debouncing and one
// servo_slew_channel per finger. Optional ramping via GESTURE_POSE_SLEW_EN.
module gesture_pose_ctrl
  import gesture_pkg::*;
#(
  parameter int unsigned NUM_CH        = 5,
  parameter int unsigned NUM_POSES     = 8,
  parameter int unsigned CLK_HZ        = 50_000_000,
  parameter int unsigned PERIOD_US     = 20000,
  parameter int unsigned STEP_US       = 10,
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             gesture,
  output logic [NUM_CH-1:0]      pwm_out,
  output logic [NUM_CH*16-1:0]   width_us,
  output logic                   frame_start,
  output logic                   busy
);

  localparam int unsigned DIV   = CLK_HZ / 1_000_000;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SC_W  = (STABLE_FRAMES > 0) ? $clog2(STABLE_FRAMES + 1) : 1;

  logic [PRE_W-1:0] r_pre;
  logic [15:0]      r_us_cnt;
  logic             r_frame_start;
  logic [7:0]       r_cand;
  logic [SC_W-1:0]  r_cnt;

  logic             w_us_tick;
  logic [SC_W-1:0]  w_cnt_nxt;
  logic             w_accept;
  pose_sel_t        w_sel;
  logic [NUM_CH-1:0] w_busy;

  assign w_us_tick = (r_pre == PRE_W'(DIV - 1));
  assign w_sel     = decode_gesture(gesture, NUM_POSES);

  always_comb begin
    w_cnt_nxt = '0;
    if (gesture == r_cand) begin
      w_cnt_nxt = r_cnt;
      if (r_cnt != SC_W'(STABLE_FRAMES)) w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  // The new candidate is always the sampled gesture, so its pose is decoded
  // straight from the input on the accepting edge.
  assign w_accept = r_frame_start && (w_cnt_nxt == SC_W'(STABLE_FRAMES));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre         <= '0;
      r_us_cnt      <= '0;
      r_frame_start <= 1'b0;
      r_cand        <= '0;
      r_cnt         <= '0;
    end else begin
      r_frame_start <= 1'b0;
      r_pre         <= w_us_tick ? '0 : r_pre + 1'b1;
      if (w_us_tick) begin
        if (r_us_cnt == 16'(PERIOD_US - 1)) begin
          r_us_cnt      <= '0;
          r_frame_start <= 1'b1;
        end else begin
          r_us_cnt <= r_us_cnt + 1'b1;
        end
      end
      if (r_frame_start) begin
        r_cand <= gesture;
        r_cnt  <= w_cnt_nxt;
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [15:0] w_pose_us;
    assign w_pose_us = pose_us(w_sel, i);

    servo_slew_channel #(
      .STEP_US(STEP_US)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .i_frame_start(r_frame_start),
      .i_load       (w_accept),
      .i_pose_us    (w_pose_us),
      .i_us_cnt     (r_us_cnt),
      .o_pwm        (pwm_out[i]),
      .o_width      (width_us[16*i +: 16]),
      .o_busy       (w_busy[i])
    );
  end

  assign frame_start = r_frame_start;
  assign busy        = |w_busy;

endmodule

// File: tb/tb_gesture_pose_ctrl.sv
// Directed bench for gesture_pose_ctrl with a shortened frame (2 clk/us,
// 1600 us); expectations follow GESTURE_POSE_SLEW_EN when it is defined.
`timescale 1ns/1ps
module tb_gesture_pose_ctrl;

  localparam int NUM_CH    = 5;
  localparam int FRAME_CYC = 3200;

`ifdef GESTURE_POSE_SLEW_EN
  localparam int W12    = 1490;
  localparam bit BUSY12 = 1'b1;
`else
  localparam int W12    = 1400;
  localparam bit BUSY12 = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [7:0]            gesture = '0;
  logic [NUM_CH-1:0]     pwm_out;
  logic [NUM_CH*16-1:0]  width_us;
  logic                  frame_start;
  logic                  busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_busy  = 1'b0;
  bit busy_seen = 1'b0;

  gesture_pose_ctrl #(
    .NUM_CH       (NUM_CH),
    .NUM_POSES    (8),
    .CLK_HZ       (2_000_000),
    .PERIOD_US    (1600),
    .STEP_US      (10),
    .STABLE_FRAMES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gesture    (gesture),
    .pwm_out    (pwm_out),
    .width_us   (width_us),
    .frame_start(frame_start),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_busy && busy) busy_seen = 1'b1;

  initial begin
    #950_000;
    $display("FAIL watchdog: run did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] wall(input int unsigned v);
    return {5{16'(v)}};
  endfunction

  function automatic logic [79:0] wv(input int unsigned a, b, c, d, e);
    return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < FRAME_CYC + 800) begin
      @(negedge clk);
      n++;
    end
    if (frame_start !== 1'b1) check_eq(tag, 80'd0, 80'd1);
  endtask

  task automatic next_frame(input string tag);
    wait_fs(tag);
    @(negedge clk);
  endtask

  // Starts on a frame_start negedge, ends on the next one.
  task automatic measure_frame(input logic [7:0] g_mid, output int hi0, output int hi4,
                               output int nfs, output int wchg, output logic [79:0] wfirst);
    logic [7:0] g_keep;
    g_keep = gesture;
    hi0 = 0; hi4 = 0; nfs = 0; wchg = 0; wfirst = '0;
    for (int n = 1; n <= FRAME_CYC; n++) begin
      @(negedge clk);
      if (n == 1) wfirst = width_us;
      else if (width_us !== wfirst) wchg++;
      if (n == 1000) gesture = g_mid;
      if (n == 2500) gesture = g_keep;
      hi0 += int'(pwm_out[0]);
      hi4 += int'(pwm_out[NUM_CH-1]);
      nfs += int'(frame_start);
    end
  endtask

  initial begin
    int hi0, hi4, nfs, wchg, cnt;
    logic [79:0] wfirst;

    rst = 1'b1;
    gesture = 8'h00;
    repeat (4) @(negedge clk);
    check_eq("rst_pwm",   80'(pwm_out), 80'd0);
    check_eq("rst_fs",    80'(frame_start), 80'd0);
    check_eq("rst_width", width_us, wall(1500));
    check_eq("rst_busy",  80'(busy), 80'd0);

    rst = 1'b0;
    cnt = 0;
    while (frame_start !== 1'b1 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("first_fs_latency", 80'(cnt), 80'd3200);

    measure_frame(8'h00, hi0, hi4, nfs, wchg, wfirst);
    check_eq("neutral_pwm_ch0", 80'(hi0), 80'd3000);
    check_eq("neutral_pwm_ch4", 80'(hi4), 80'd3000);
    check_eq("frame_period",    80'(nfs), 80'd1);
    check_eq("neutral_width",   wfirst, wall(1500));
    @(negedge clk);

    mon_busy = 1'b1;
    gesture = 8'h06;
    repeat (3) next_frame("fs_multihot");
    check_eq("multihot_width", width_us, wall(1500));

    for (int i = 0; i < 4; i++) begin
      gesture = (i % 2 == 0) ? 8'h01 : 8'h02;
      next_frame("fs_toggle");
      check_eq("toggle_width", width_us, wall(1500));
    end
    mon_busy = 1'b0;
    check_eq("busy_never", 80'(busy_seen), 80'd0);

    next_frame("fs_hold1");
    check_eq("hold1_busy",  80'(busy), 80'd0);
    check_eq("hold1_width", width_us, wall(1500));

    wait_fs("fs_accept");
    measure_frame(8'h04, hi0, hi4, nfs, wchg, wfirst);
    check_eq("accept_width_held", wfirst, wall(1500));
    check_eq("midframe_wchg",     80'(wchg), 80'd0);
    check_eq("midframe_pwm",      80'(hi0), 80'd3000);
    check_eq("accept_busy",       80'(busy), 80'd1);

    measure_frame(8'h02, hi0, hi4, nfs, wchg, wfirst);
    check_eq("first_move_width", wfirst, wall(W12));
    check_eq("first_move_pwm",   80'(hi0), 80'(2 * W12));
    check_eq("first_move_busy",  80'(busy), 80'(BUSY12));

`ifdef GESTURE_POSE_SLEW_EN
    for (int k = 2; k <= 10; k++) begin
      @(negedge clk);
      check_eq("slew_width", width_us, wall(1500 - 10 * k));
      check_eq("slew_busy",  80'(busy), 80'(k < 10));
      if (k < 10) wait_fs("fs_slew");
    end
`else
    @(negedge clk);
    check_eq("step_hold_width", width_us, wall(1400));
    check_eq("step_hold_busy",  80'(busy), 80'd0);
    gesture = 8'h80;
    repeat (3) next_frame("fs_clamp");
    check_eq("clamp_pre_width", width_us, wall(1400));
    check_eq("clamp_pre_busy",  80'(busy), 80'd1);
    next_frame("fs_clamp_apply");
    check_eq("clamp_width", width_us, wv(2000, 1000, 1700, 1500, 1300));
    check_eq("clamp_busy",  80'(busy), 80'd0);
`endif

    repeat (1000) @(negedge clk);
    check_eq("pre_rst_pwm0", 80'(pwm_out[0]), 80'd1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("midrst_pwm",   80'(pwm_out), 80'd0);
    check_eq("midrst_width", width_us, wall(1500));
    check_eq("midrst_busy",  80'(busy), 80'd0);
    check_eq("midrst_fs",    80'(frame_start), 80'd0);
    rst = 1'b0;
    cnt = 0;
    while (frame_start !== 1'b1 && cnt < 5000) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("post_rst_frame", 80'(cnt), 80'd3200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gesture_pose_ctrl.md
GESTURE_POSE_CTRL -- requirements
Module: gesture_pose_ctrl

Interface
REQ-001 SHALL have parameter NUM_CH, default 5, number of servo channels (thumb..pinky = 0..4).
REQ-002 SHALL have parameter NUM_POSES, default 8, one pose per gesture bit; NUM_POSES <= 8.
REQ-003 SHALL have parameter CLK_HZ, default 50_000_000, clock frequency; CLK_HZ/1_000_000 is an integer >= 2.
REQ-004 SHALL have parameter PERIOD_US, default 20000, PWM frame length in us.
REQ-005 SHALL have parameter STEP_US, default 10, maximum width change per channel per frame.
REQ-006 SHALL have parameter STABLE_FRAMES, default 2, consecutive frames a gesture must hold before acceptance.
REQ-007 SHALL have port clk, input, 1, system clock.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port gesture, input, 8, gesture code from the classifier.
REQ-010 SHALL have port pwm_out, output, NUM_CH, registered servo PWM per channel.
REQ-011 SHALL have port width_us, output, NUM_CH*16, current pulse width per channel; channel i at bits [16i+15:16i].
REQ-012 SHALL have port frame_start, output, 1, one-cycle pulse on the first cycle of each frame.
REQ-013 SHALL have port busy, output, 1, high while any channel width differs from its target.

Function
REQ-014 SHALL generate us_tick every CLK_HZ/1_000_000 clocks from a prescaler; us_cnt SHALL count 0..PERIOD_US-1 on us_tick and wrap to 0.
REQ-015 SHALL assert frame_start for exactly one clock when us_cnt wraps to 0.
REQ-016 SHALL register pwm_out[i] = (us_cnt < width[i]), so the output lags the counter by one clock.
REQ-017 SHALL decode gesture: exactly one bit k set with k < NUM_POSES selects pose k; zero bits, multiple bits, or k >= NUM_POSES select the neutral pose.
REQ-018 SHALL sample gesture only on frame_start; equal to the candidate: stable count increments, saturating at STABLE_FRAMES; otherwise: candidate = gesture, count = 0.
REQ-019 SHALL load the target from the candidate's pose when the count reaches STABLE_FRAMES; the accepted gesture otherwise holds.
REQ-020 SHALL update width[i] only on frame_start, never mid-frame, so pulses are glitch-free.
REQ-021 SHALL clamp every pose-table value to MIN_US..MAX_US before use as a target.
REQ-022 SHALL compute busy combinationally as OR over channels of (width[i] != target[i]).
REQ-023 SHALL let gesture changes during ramping retarget on acceptance; the ramp continues from the current width with no jump.

Reset
REQ-024 SHALL, while rst is high at a clock edge, clear the prescaler, us_cnt, candidate, count, pwm_out and frame_start to 0, and set width and target to NEUTRAL_US; busy = 0.
REQ-025 SHALL, on rst asserted mid-frame, force pwm_out low on the next clock and start a full frame after release.

Configuration
REQ-026 SHALL, with GESTURE_POSE_SLEW_EN defined, move width[i] toward target[i] by min(STEP_US, |diff|) per frame_start.
REQ-027 SHALL, without GESTURE_POSE_SLEW_EN, set width[i] = target[i] on the first frame_start after acceptance; busy is then high for at most one frame.

Structure
REQ-028 SHALL take NEUTRAL_US (1500), MIN_US (1000), MAX_US (2000) and the POSE_TABLE constant [NUM_POSES][NUM_CH] of 16-bit widths from the shared package gesture_pkg; pose 0 = all 1500, pose 1 = all 1400.
REQ-029 SHALL instantiate sub-module servo_slew_channel once per channel; it holds width/target, performs clamping and slewing, and drives that channel's pwm compare.

Verification
REQ-030 SHALL check: reset -> all width_us = 1500, pwm_out high for 1500 us of each 20000 us frame.
REQ-031 SHALL check: gesture = 0x02 held 3 frames, slew on -> target 1400 accepted at frame 2, widths 1490, 1480, ... reach 1400 after 10 frames, then busy = 0.
REQ-032 SHALL check: gesture = 0x06 (multi-hot) -> neutral 1500; busy never asserted from reset.
REQ-033 SHALL check: gesture toggles 0x01/0x02 every frame -> never accepted, widths stay 1500.
REQ-034 SHALL check: gesture changes mid-frame -> pwm_out width is unchanged until the next frame_start.
REQ-035 SHALL check: slew off, 0x02 accepted -> width 1400 on the next frame_start; rst mid-frame -> pwm_out = 0 next clock and width = 1500.
